// File: rtl/shift_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// shift_arbiter_pkg
//
// Shared definitions for the shift arbiter and its shifter datapath:
//   - state_t   : arbiter FSM states (IDLE, EXEC, RESP)
//   - SH_*      : shift-type encodings carried on req_c
//   - widths of the operand, shift amount and shift type fields
// -----------------------------------------------------------------------------
package shift_arbiter_pkg;

    // Field widths of one requester's operand bundle.
    localparam int OPND_W  = 32;
    localparam int SHAMT_W = 5;
    localparam int SHTYP_W = 2;

    // Shift-type encodings. Any code with bit 1 clear (00 or 01) is a left
    // shift; SH_LEFT is the canonical form.
    localparam logic [SHTYP_W-1:0] SH_LEFT   = 2'b00;
    localparam logic [SHTYP_W-1:0] SH_LRIGHT = 2'b10;
    localparam logic [SHTYP_W-1:0] SH_ARIGHT = 2'b11;

    // Arbiter FSM: grant in IDLE, compute in EXEC, present result in RESP.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/shift_arbiter_shifter.sv
// -----------------------------------------------------------------------------
// shifter_32
//
// Purely combinational 32-bit barrel shifter used by shift_arbiter.
//
// Ports:
//   a  in  32  operand
//   b  in   5  unsigned shift amount (0..31)
//   c  in   2  shift type: 0x left, 10 logical right, 11 arithmetic right
//   z  out 32  shifted result
//
// b = 0 passes a through unchanged for every shift type.
// -----------------------------------------------------------------------------
module shifter_32
    import shift_arbiter_pkg::*;
(
    input  logic [OPND_W-1:0]  a,
    input  logic [SHAMT_W-1:0] b,
    input  logic [SHTYP_W-1:0] c,
    output logic [OPND_W-1:0]  z
);

    // Signed view of the operand so that >>> replicates a[31].
    logic signed [OPND_W-1:0] a_s;

    assign a_s = signed'(a);

    always_comb begin
        case (c)
            SH_LRIGHT: z = a >> b;
            SH_ARIGHT: z = $unsigned(a_s >>> b);
            default:   z = a << b;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//
// Shares one 32-bit shifter between NREQ requesters. A round-robin grant is
// issued in IDLE; the accepted operands are registered, shifted during EXEC,
// and the registered result is held in RESP until the owner accepts it.
// With no backpressure one operation completes every 3 cycles.
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   CNTW  width of the completed-operation counter
//
// Ports:
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   req_valid  in   NREQ     request strobes
//   req_ready  out  NREQ     grant; only the granted index is high, IDLE only
//   req_a      in   NREQ*32  operands, requester i at [32i+31:32i]
//   req_b      in   NREQ*5   shift amounts, requester i at [5i+4:5i]
//   req_c      in   NREQ*2   shift types, requester i at [2i+1:2i]
//   rsp_valid  out  NREQ     one-hot result valid for the owner
//   rsp_ready  in   NREQ     result accept; only the owner's bit is looked at
//   rsp_z      out  32       result, meaningful while rsp_valid != 0
//   busy       out  1        high whenever the FSM is not in IDLE
//   op_count   out  CNTW     completed response handshakes, wrapping
// -----------------------------------------------------------------------------
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int CNTW = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*OPND_W-1:0]    req_a,
    input  logic [NREQ*SHAMT_W-1:0]   req_b,
    input  logic [NREQ*SHTYP_W-1:0]   req_c,
    output logic [NREQ-1:0]           rsp_valid,
    input  logic [NREQ-1:0]           rsp_ready,
    output logic [OPND_W-1:0]         rsp_z,
    output logic                      busy,
    output logic [CNTW-1:0]           op_count
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t               state;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        owner;

    // Round-robin search result and the winner's operand bundle.
    logic                 gnt_found;
    logic [PW-1:0]        gnt_idx;
    logic [OPND_W-1:0]    sel_a;
    logic [SHAMT_W-1:0]   sel_b;
    logic [SHTYP_W-1:0]   sel_c;

    // Operand registers feeding the shifter during EXEC.
    logic [OPND_W-1:0]    a_p0;
    logic [SHAMT_W-1:0]   b_p0;
    logic [SHTYP_W-1:0]   c_p0;
    logic [OPND_W-1:0]    z_p0;

    // ---- stage 0: round-robin grant search starting at ptr ----
    always_comb begin
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_c     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx[PW-1:0];
                sel_a     = req_a[OPND_W*idx +: OPND_W];
                sel_b     = req_b[SHAMT_W*idx +: SHAMT_W];
                sel_c     = req_c[SHTYP_W*idx +: SHTYP_W];
            end
        end
    end

    // The grant is combinational from req_valid so a requester can be taken
    // in the same cycle it raises its request. Gating with rst_n keeps every
    // ready low while reset is held, even though state already reads IDLE.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state == IDLE) && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // ---- stage 1: shared shift datapath on the registered operands ----
    shifter_32 u_shifter (
        .a (a_p0),
        .b (b_p0),
        .c (c_p0),
        .z (z_p0)
    );

    // ---- stage 2: sequencing, result register and completion count ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            a_p0      <= '0;
            b_p0      <= '0;
            c_p0      <= '0;
            rsp_z     <= '0;
            rsp_valid <= '0;
            busy      <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        a_p0  <= sel_a;
                        b_p0  <= sel_b;
                        c_p0  <= sel_c;
                        owner <= gnt_idx;
                        // Wrap explicitly: NREQ need not be a power of two.
                        ptr   <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_z     <= z_p0;
                    rsp_valid <= NREQ'(1) << owner;
                    state     <= RESP;
                end
                RESP: begin
                    // Non-owner rsp_ready bits are deliberately not looked at.
                    if (rsp_ready[owner]) begin
                        rsp_valid <= '0;
                        busy      <= 1'b0;
                        op_count  <= op_count + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter
//
// Self-checking bench for shift_arbiter. A transaction-level model tracks the
// round-robin pointer, the in-flight operation and the completed count, and
// predicts every output each cycle; the expected shift result is computed with
// plain integer arithmetic (multiply / floor-divide by powers of two).
// -----------------------------------------------------------------------------
module tb_shift_arbiter;

    localparam int NREQ = 4;
    localparam int CNTW = 16;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_a;
    logic [NREQ*5-1:0]    req_b;
    logic [NREQ*2-1:0]    req_c;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [31:0]          rsp_z;
    logic                 busy;
    logic [CNTW-1:0]      op_count;

    shift_arbiter #(.NREQ(NREQ), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    bit              m_busy;
    int              m_age;      // edges since the accept edge, accept edge = 1
    int              m_owner;
    int              m_ptr;
    logic [31:0]     m_z;
    logic [CNTW-1:0] m_count;
    int              grants[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input int b,
                                              input logic [1:0] c);
        longint p, s, r, two32;
        two32 = 64'sh1_0000_0000;
        p = 1;
        for (int i = 0; i < b; i++) p = p * 2;
        s = longint'(a);
        if (c[1] == 1'b0) begin
            r = (s * p) % two32;
        end else if (c[0] == 1'b0) begin
            r = s / p;
        end else begin
            if (a[31]) s = s - two32;
            if (s >= 0) r = s / p;
            else        r = -((-s + p - 1) / p);
        end
        return r[31:0];
    endfunction

    function automatic int pick(input int ptr, input logic [NREQ-1:0] v);
        for (int j = 0; j < NREQ; j++) begin
            if (v[(ptr + j) % NREQ]) return (ptr + j) % NREQ;
        end
        return -1;
    endfunction

    // Called just after a negedge with inputs driven; checks, then advances
    // one clock and returns on the following negedge.
    task automatic step();
        logic [NREQ-1:0] e_ready;
        logic [NREQ-1:0] e_rvalid;
        int g;
        #1;
        e_ready  = '0;
        e_rvalid = '0;
        g        = -1;
        if (!m_busy) begin
            g = pick(m_ptr, req_valid);
            if (g >= 0) e_ready[g] = 1'b1;
        end else if (m_age >= 2) begin
            e_rvalid[m_owner] = 1'b1;
        end
        chk("req_ready", req_ready, e_ready);
        chk("rsp_valid", rsp_valid, e_rvalid);
        chk("busy", busy, m_busy);
        chk("op_count", op_count, m_count);
        if (m_busy && m_age >= 2) chk("rsp_z", rsp_z, m_z);
        @(posedge clk);
        if (!m_busy) begin
            if (g >= 0) begin
                m_busy  = 1'b1;
                m_age   = 1;
                m_owner = g;
                m_ptr   = (g + 1) % NREQ;
                m_z     = ref_shift(req_a[32*g +: 32], int'(req_b[5*g +: 5]), req_c[2*g +: 2]);
                grants.push_back(g);
            end
        end else if (m_age >= 2 && rsp_ready[m_owner]) begin
            m_busy  = 1'b0;
            m_count = m_count + 1'b1;
        end else begin
            m_age++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, '0);
        chk("rst_rsp_valid", rsp_valid, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_op_count", op_count, '0);
        chk("rst_rsp_z", rsp_z, '0);
        m_busy  = 1'b0;
        m_age   = 0;
        m_owner = 0;
        m_ptr   = 0;
        m_count = '0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_held_req_ready", req_ready, '0);
        chk("rst_held_busy", busy, 1'b0);
        rst_n = 1'b1;
    endtask

    // One operation on requester r; extra keeps other requesters' valids up.
    task automatic run_op(input int r, input logic [31:0] a, input logic [4:0] b,
                          input logic [1:0] c, input logic [NREQ-1:0] extra,
                          input int hold, output logic [31:0] z_seen, output int lat);
        int n;
        req_valid          = extra;
        req_valid[r]       = 1'b1;
        req_a[32*r +: 32]  = a;
        req_b[5*r +: 5]    = b;
        req_c[2*r +: 2]    = c;
        rsp_ready          = '0;
        n = 0;
        while (!m_busy && n < 20) begin
            step();
            n++;
        end
        chk("op_accepted", busy, 1'b1);
        req_valid[r] = 1'b0;
        lat = 1;
        n   = 0;
        while (!rsp_valid[r] && n < 10) begin
            step();
            lat++;
            n++;
        end
        z_seen = rsp_z;
        repeat (hold) step();
        if (hold > 0) chk("hold_z_stable", rsp_z, z_seen);
        rsp_ready[r] = 1'b1;
        step();
        rsp_ready = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] z;
        int lat;
        int sweep_ok;
        logic [1:0] ctypes [3];
        int exp_order [5];

        rst_n     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_c     = '0;
        rsp_ready = '0;
        @(negedge clk);

        // Reset with every requester asking: nothing may be granted.
        req_valid = '1;
        do_reset();
        req_valid = '0;

        // Single left shift of a 1 into the MSB, fixed latency, count = 1.
        run_op(0, 32'h0000_0001, 5'd31, 2'b00, '0, 0, z, lat);
        chk("r029_z", z, 32'h8000_0000);
        chk("r029_latency", lat, 2);
        chk("r029_count", op_count, 1);

        // Arithmetic then logical right shift on requester 1.
        run_op(1, 32'h8000_0000, 5'd4, 2'b11, '0, 0, z, lat);
        chk("r030_arith", z, 32'hF800_0000);
        run_op(1, 32'hF000_0000, 5'd4, 2'b10, '0, 0, z, lat);
        chk("r030_logic", z, 32'h0F00_0000);
        chk("r030_count", op_count, 3);

        // All requesters valid from reset: strict rotation 0,1,2,3,0.
        req_valid = '1;
        rsp_ready = '1;
        for (int r = 0; r < NREQ; r++) begin
            req_a[32*r +: 32] = $urandom;
            req_b[5*r +: 5]   = 5'($urandom);
            req_c[2*r +: 2]   = 2'($urandom);
        end
        do_reset();
        grants.delete();
        repeat (16) step();
        exp_order = '{0, 1, 2, 3, 0};
        chk("r031_enough_grants", grants.size() >= 5, 1'b1);
        if (grants.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk($sformatf("r031_grant%0d", k), grants[k], exp_order[k]);
        end
        req_valid = '0;
        rsp_ready = '0;

        // Owner 2 stalls the response 5 cycles while requester 3 waits.
        do_reset();
        run_op(2, 32'h1234_5678, 5'd7, 2'b10, 4'b1000, 5, z, lat);
        chk("r032_z", z, 32'h0024_68AC);
        chk("r032_next_grant", req_ready, 4'b1000);
        run_op(3, 32'hDEAD_BEEF, 5'd0, 2'b11, '0, 0, z, lat);
        chk("r032_b0_passthru", z, 32'hDEAD_BEEF);

        // Reset during EXEC discards the operation.
        do_reset();
        req_valid         = 4'b0010;
        req_a[32*1 +: 32] = 32'h0000_00FF;
        req_b[5*1 +: 5]   = 5'd3;
        req_c[2*1 +: 2]   = 2'b00;
        step();
        chk("r033_in_exec", busy, 1'b1);
        req_valid = '0;
        rsp_ready = '1;
        do_reset();
        repeat (4) step();
        chk("r033_count", op_count, 0);
        rsp_ready = '0;

        // Full shift-amount sweep for each shift type.
        ctypes   = '{2'b00, 2'b10, 2'b11};
        sweep_ok = 0;
        for (int t = 0; t < 3; t++) begin
            for (int b = 0; b < 32; b++) begin
                run_op(0, 32'hA5A5_A5A5, 5'(b), ctypes[t], '0, 0, z, lat);
                if (z === ref_shift(32'hA5A5_A5A5, b, ctypes[t])) sweep_ok++;
            end
        end
        chk("r034_sweep_matches", sweep_ok, 96);

        // Random traffic: flickering valids, random operands and rsp_ready.
        for (int i = 0; i < 500; i++) begin
            for (int r = 0; r < NREQ; r++) begin
                req_valid[r]      = ($urandom_range(0, 3) != 0);
                req_a[32*r +: 32] = $urandom;
                req_b[5*r +: 5]   = 5'($urandom);
                req_c[2*r +: 2]   = 2'($urandom);
            end
            rsp_ready = NREQ'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
